ram_bist_ctrl: RTL and testbench

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

---
 rtl/ram_bist_ctrl.sv | 157 +++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - RAM BIST controller: fill every address with a pattern, read it back, count mismatches
module ram_bist_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  write,
  output logic                  read,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int DRAIN_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                state;
  logic                  armed;
  logic [1:0]            mode_q;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_nxt;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic [RD_LATENCY-1:0] pipe_vld;
  logic [ADDR_WIDTH-1:0] pipe_addr [RD_LATENCY];
  logic                  mismatch;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [1:0] m, input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] p;
    p = '0;
    case (m)
      2'd0: p = DATA_WIDTH'(a);
      2'd1: p = ~DATA_WIDTH'(a);
      // Checkerboard: 0xAA.. on even addresses, 0x55.. on odd ones.
      2'd2: for (int i = 0; i < DATA_WIDTH; i++) p[i] = (i % 2 == 1) ^ a[0];
      default: p = '1;
    endcase
    return p;
  endfunction

  assign cnt_nxt  = cnt + 1'b1;
  assign mismatch = pipe_vld[RD_LATENCY-1] &&
                    (data_out != pattern(mode_q, pipe_addr[RD_LATENCY-1]));

  // Each issued read travels alongside its address until its data returns.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_addr[i] <= '0;
    end else begin
      pipe_vld[0]  <= read;
      pipe_addr[0] <= rd_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      armed          <= 1'b0;
      mode_q         <= 2'd0;
      cnt            <= '0;
      drain_cnt      <= '0;
      data_in        <= '0;
      wr_addr        <= '0;
      rd_addr        <= '0;
      write          <= 1'b0;
      read           <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) first_err_addr <= pipe_addr[RD_LATENCY-1];
      end
      case (state)
        IDLE: begin
          if (start && armed) begin
            state          <= WRITE;
            mode_q         <= mode;
            cnt            <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            write          <= 1'b1;
            wr_addr        <= '0;
            data_in        <= pattern(mode, '0);
          end
        end
        WRITE: begin
          if (cnt == ADDR_LAST) begin
            state   <= READ;
            cnt     <= '0;
            write   <= 1'b0;
            wr_addr <= '0;
            data_in <= '0;
            read    <= 1'b1;
            rd_addr <= '0;
          end else begin
            cnt     <= cnt_nxt;
            wr_addr <= cnt_nxt;
            data_in <= pattern(mode_q, cnt_nxt);
          end
        end
        READ: begin
          if (cnt == ADDR_LAST) begin
            state     <= DRAIN;
            cnt       <= '0;
            read      <= 1'b0;
            rd_addr   <= '0;
            drain_cnt <= '0;
          end else begin
            cnt     <= cnt_nxt;
            rd_addr <= cnt_nxt;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            // The final read is compared on this same edge.
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb/tb_ram_bist_ctrl.sv - self-checking bench for ram_bist_ctrl with a behavioural RAM and fault injection
module tb_ram_bist_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int L  = 3;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [1:0]    mode;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_in;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          write;
  logic          read;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;

  ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(L)) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .data_out(data_out),
    .data_in(data_in), .wr_addr(wr_addr), .rd_addr(rd_addr), .write(write), .read(read),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wcnt, rcnt, seq_bad, overlap, idle_bad;
  logic [1:0] tmode;

  logic [DW-1:0] mem   [N];
  logic [DW-1:0] flip  [N];
  logic          zero_all;
  logic [DW-1:0] rpipe [L];

  typedef struct {
    logic [1:0] mode;
    int         fault;
    int         exp_err;
    int         exp_first;
    bit         exp_pass;
  } vec_t;
  vec_t vecs [7];

  function automatic logic [DW-1:0] pat(input logic [1:0] m, input int a);
    case (m)
      2'd0:    return DW'(a);
      2'd1:    return ~DW'(a);
      2'd2:    return (a % 2 == 0) ? 16'hAAAA : 16'h5555;
      default: return 16'hFFFF;
    endcase
  endfunction

  // Reference: a read mismatches when the faulty RAM returns anything other than what was written.
  task automatic model(input logic [1:0] m, output int e, output int f);
    logic [DW-1:0] p;
    logic [DW-1:0] rd;
    e = 0;
    f = 0;
    for (int a = 0; a < N; a++) begin
      p  = pat(m, a);
      rd = zero_all ? '0 : (p ^ flip[a]);
      if (rd != p) begin
        if (e == 0) f = a;
        e++;
      end
    end
  endtask

  always @(posedge clk) begin
    if (write) mem[wr_addr] <= data_in;
    rpipe[0] <= read ? (zero_all ? '0 : (mem[rd_addr] ^ flip[rd_addr])) : DW'($urandom);
    for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
  end
  assign data_out = rpipe[L-1];

  always @(negedge clk) begin
    if (resetn) begin
      if (write) begin
        if (int'(wr_addr) != wcnt || data_in != pat(tmode, int'(wr_addr))) seq_bad++;
        wcnt++;
      end
      if (read) begin
        if (int'(rd_addr) != rcnt || wcnt != N) seq_bad++;
        rcnt++;
      end
      if (write && read) overlap++;
      if (!busy && (data_in != '0 || wr_addr != '0 || rd_addr != '0 || write || read)) idle_bad++;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic apply_fault(input int f);
    for (int a = 0; a < N; a++) flip[a] = '0;
    zero_all = 1'b0;
    case (f)
      1: begin flip[5] = 16'h0100; flip[9] = 16'h8001; end
      2: zero_all = 1'b1;
      3: flip[15] = 16'h0001;
      4: flip[0] = 16'h4000;
      default: ;
    endcase
  endtask

  task automatic launch(input logic [1:0] m);
    @(negedge clk);
    wcnt = 0; rcnt = 0; seq_bad = 0; tmode = m;
    start = 1'b1;
    mode  = m;
    @(posedge clk);
  endtask

  // Entered right after the edge that accepted start; that edge counts as cycle 1.
  task automatic finish_test(input logic [1:0] m, input int ee, input int ef, input bit ep, input string nm);
    int k;
    int bb;
    k = 1;
    bb = 0;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;
    while (!done && k < 200) begin
      if (!busy) bb++;
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    chk({nm, ":length"}, k, 2 * N + L + 1);
    chk({nm, ":busy_at_done"}, busy, 1);
    chk({nm, ":busy_gaps"}, bb, 0);
    chk({nm, ":err_count"}, err_count, ee);
    chk({nm, ":first_err_addr"}, first_err_addr, ef);
    chk({nm, ":pass"}, pass, ep);
    chk({nm, ":writes"}, wcnt, N);
    chk({nm, ":reads"}, rcnt, N);
    chk({nm, ":sequence"}, seq_bad, 0);
    @(posedge clk);
    @(negedge clk);
    chk({nm, ":done_one_cycle"}, done, 0);
    chk({nm, ":busy_after"}, busy, 0);
    chk({nm, ":pass_held"}, pass, ep);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e, f, found, dn, gaps, gap_at, d0, d1;
    logic [1:0] m;
    int done_at [$];

    vecs[0] = '{2'd0, 0, 0,  0,  1'b1};
    vecs[1] = '{2'd2, 1, 2,  5,  1'b0};
    vecs[2] = '{2'd3, 2, 16, 0,  1'b0};
    vecs[3] = '{2'd1, 3, 1,  15, 1'b0};
    vecs[4] = '{2'd1, 0, 0,  0,  1'b1};
    vecs[5] = '{2'd0, 2, 15, 1,  1'b0};
    vecs[6] = '{2'd2, 4, 1,  0,  1'b0};

    resetn = 1'b0; start = 1'b0; mode = 2'd0;
    wcnt = 0; rcnt = 0; seq_bad = 0; overlap = 0; idle_bad = 0; tmode = 2'd0;
    apply_fault(0);
    repeat (3) @(negedge clk);
    chk("reset:data_in", data_in, 0);
    chk("reset:wr_addr", wr_addr, 0);
    chk("reset:rd_addr", rd_addr, 0);
    chk("reset:write", write, 0);
    chk("reset:read", read, 0);
    chk("reset:busy", busy, 0);
    chk("reset:done", done, 0);
    chk("reset:pass", pass, 0);
    chk("reset:err_count", err_count, 0);
    chk("reset:first_err_addr", first_err_addr, 0);

    // start held across the first edge after reset release must be ignored there
    start = 1'b1; mode = 2'd0; resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset:first_edge_ignored", busy, 0);
    wcnt = 0; rcnt = 0; seq_bad = 0; tmode = 2'd0;
    @(posedge clk);
    finish_test(2'd0, 0, 0, 1'b1, "post_reset");

    for (int v = 0; v < 7; v++) begin
      apply_fault(vecs[v].fault);
      launch(vecs[v].mode);
      finish_test(vecs[v].mode, vecs[v].exp_err, vecs[v].exp_first, vecs[v].exp_pass, $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 6; r++) begin
      m = 2'($urandom_range(0, 3));
      for (int a = 0; a < N; a++) flip[a] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : '0;
      zero_all = ($urandom_range(0, 7) == 0);
      model(m, e, f);
      launch(m);
      finish_test(m, e, f, (e == 0), $sformatf("rand%0d", r));
    end

    // Abort during the read phase, then a fresh all-ones test
    apply_fault(0);
    launch(2'd2);
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int j = 0; j < 100 && found == 0; j++) begin
      if (read && rd_addr == 4'd7) found = 1;
      else begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    chk("abort:reached_read7", found, 1);
    #1 resetn = 1'b0;
    #1;
    chk("abort:busy_cleared", busy, 0);
    chk("abort:outputs_zero", {data_in, wr_addr, rd_addr, write, read, busy, done, pass, err_count, first_err_addr}, 0);
    dn = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort:no_done", dn, 0);
    start = 1'b1; mode = 2'd3; resetn = 1'b1;
    wcnt = 0; rcnt = 0; seq_bad = 0; tmode = 2'd3;
    @(posedge clk);
    @(negedge clk);
    chk("abort:first_edge_ignored", busy, 0);
    @(posedge clk);
    finish_test(2'd3, 0, 0, 1'b1, "restart_m3");

    // start held for 40 cycles: one test, one idle cycle, then a second test
    @(negedge clk);
    apply_fault(0);
    start = 1'b1; mode = 2'd1; tmode = 2'd1;
    gaps = 0; gap_at = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) done_at.push_back(i);
      if (!busy && i < 2 * (2 * N + L + 2) - 2) begin
        gaps++;
        gap_at = i;
      end
      if (i == 39) start = 1'b0;
    end
    d0 = (done_at.size() > 0) ? done_at[0] : -1;
    d1 = (done_at.size() > 1) ? done_at[1] : -1;
    chk("held:done_count", done_at.size(), 2);
    chk("held:first_done", d0, 2 * N + L);
    chk("held:second_done", d1, 2 * (2 * N + L) + 2);
    chk("held:idle_cycles", gaps, 1);
    chk("held:idle_at", gap_at, 2 * N + L + 1);
    chk("held:pass", pass, 1);
    chk("held:err_count", err_count, 0);

    chk("global:write_read_overlap", overlap, 0);
    chk("global:idle_outputs_nonzero", idle_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
